// File: rtl/gc_pack_pkg.sv
// Shared types and tag encodings for the GarbledCircuit stream packer.
package gc_pack_pkg;

  typedef enum logic [1:0] {
    LABEL = 2'd0,
    KEY   = 2'd1,
    TABLE = 2'd2,
    MASK  = 2'd3
  } rec_type_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DRAIN  = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [2:0] TAG_KEY       = 3'b001;
  localparam logic [2:0] TAG_TABLE     = 3'b010;
  localparam logic [2:0] TAG_MASK      = 3'b011;
  localparam int         TAG_LABEL_BIT = 2;

endpackage

// File: rtl/gc_dual_write_fifo.sv
// FIFO with two write ports per cycle (port 0 lands first) and one read port.
// The head is read combinationally; when empty the last popped word is held.
module gc_dual_write_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wr_en0,
  input  logic [W-1:0]               wr_data0,
  input  logic                       wr_en1,
  input  logic [W-1:0]               wr_data1,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic [$clog2(DEPTH):0]     free
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [W-1:0]  last_reg;
  logic [AW-1:0] waddr0, waddr1, raddr;
  logic          empty;

  assign waddr0 = wr_ptr_reg[AW-1:0];
  assign waddr1 = waddr0 + AW'(wr_en0);
  assign raddr  = rd_ptr_reg[AW-1:0];
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  // Extra pointer MSB distinguishes full from empty; full is count == DEPTH.
  assign count  = wr_ptr_reg - rd_ptr_reg;
  assign free   = PW'(DEPTH) - count;

  always_ff @(posedge clk) begin
    if (wr_en0) mem[waddr0] <= wr_data0;
    if (wr_en1) mem[waddr1] <= wr_data1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      last_reg   <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_reg + PW'(wr_en0) + PW'(wr_en1);
      if (rd_en && !empty) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
        last_reg   <= mem[raddr];
      end
    end
  end

  assign rd_data = empty ? last_reg : mem[raddr];

endmodule

// File: rtl/gc_stream_packer.sv
// Packs GarbledCircuit tagged words into a single-word record stream.
// Optional protocol checker enabled by defining GC_PACK_CHECK_EN.
module gc_stream_packer
  import gc_pack_pkg::*;
#(
  parameter int S     = 5,
  parameter int K     = 128,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [2:0]   tag,
  input  logic [S-1:0] index0,
  input  logic [S-1:0] index1,
  input  logic [K-1:0] data0,
  input  logic [K-1:0] data1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [1:0]   out_type,
  output logic [S-1:0] out_index,
  output logic [K-1:0] out_data,
  output logic         out_last,
  output logic         done,
  output logic         overflow,
  output logic         error
);

  localparam int W  = 2 + S + K;
  localparam int PW = $clog2(DEPTH) + 1;

  state_t        state_reg, state_next;
  logic          we0, we1;
  logic [W-1:0]  rec0, rec1, head;
  logic [PW-1:0] count, free;
  logic [1:0]    n_words;
  logic          capture_ok, fits, is_mask, ovf, mask_drop, pop, rearm;
  logic          overflow_reg, mask_lost_reg;

  always_comb begin
    we0  = 1'b0;
    we1  = 1'b0;
    rec0 = {LABEL, index0, data0};
    rec1 = {LABEL, index1, data1};
    if (tag[TAG_LABEL_BIT]) begin
      we0 = tag[0];
      we1 = tag[1];
    end else begin
      case (tag)
        TAG_KEY: begin
          we0  = 1'b1;
          we1  = 1'b1;
          rec0 = {KEY, S'(0), data0};
          rec1 = {KEY, S'(1), data1};
        end
        TAG_TABLE: begin
          we0  = 1'b1;
          we1  = 1'b1;
          rec0 = {TABLE, index0, data0};
          rec1 = {TABLE, index1, data1};
        end
        TAG_MASK: begin
          we0  = 1'b1;
          rec0 = {MASK, S'(0), data0};
        end
        default: ;
      endcase
    end
  end

  // Room is judged on the pre-pop count, so a same-cycle pop never makes space.
  assign capture_ok = (state_reg == IDLE) || (state_reg == STREAM);
  assign n_words    = {1'b0, we0} + {1'b0, we1};
  assign fits       = PW'(n_words) <= free;
  assign is_mask    = (tag == TAG_MASK);
  assign ovf        = capture_ok && !fits;
  assign mask_drop  = ovf && is_mask;
  assign pop        = out_valid && out_ready;
  assign rearm      = (state_reg == DONE) && start;

  gc_dual_write_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en0   (capture_ok && fits && we0),
    .wr_data0 (rec0),
    .wr_en1   (capture_ok && fits && we1),
    .wr_data1 (rec1),
    .rd_en    (pop),
    .rd_data  (head),
    .count    (count),
    .free     (free)
  );

  assign out_valid = (count != '0);
  assign out_type  = head[W-1 -: 2];
  assign out_index = head[K +: S];
  assign out_data  = head[K-1:0];
  assign out_last  = out_valid && (out_type == MASK);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (is_mask) state_next = DRAIN;
              else if (tag != 3'b000) state_next = STREAM;
      STREAM: if (is_mask) state_next = DRAIN;
      // A dropped MASK never reaches the head, so finish once the FIFO runs dry.
      DRAIN:  if ((pop && out_last) || (mask_lost_reg && !out_valid)) state_next = DONE;
      DONE:   if (start) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_ff @(posedge clk) begin
    if (!rst || rearm) begin
      overflow_reg  <= 1'b0;
      mask_lost_reg <= 1'b0;
    end else begin
      if (ovf)       overflow_reg  <= 1'b1;
      if (mask_drop) mask_lost_reg <= 1'b1;
    end
  end

  assign done     = (state_reg == DONE);
  assign overflow = overflow_reg;

`ifdef GC_PACK_CHECK_EN
  logic error_reg, err_evt;

  assign err_evt = (!capture_ok && tag != 3'b000)
                || (tag == TAG_TABLE && index1 != index0 + S'(1))
                || (tag == 3'b100)
                || mask_drop;

  always_ff @(posedge clk) begin
    if (!rst || rearm) error_reg <= 1'b0;
    else if (err_evt)  error_reg <= 1'b1;
  end

  assign error = error_reg;
`else
  assign error = 1'b0;
`endif

endmodule
